// File: rtl/a23_copro_pkg.sv
// Shared CP15 transfer encodings and initiator FSM states.
package a23_copro_pkg;

  localparam logic [1:0] COPRO_OP_IDLE  = 2'd0;
  localparam logic [1:0] COPRO_OP_READ  = 2'd1;
  localparam logic [1:0] COPRO_OP_WRITE = 2'd2;

  localparam logic [3:0] COPRO_NUM_CP15 = 4'd15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } copro_state_t;

endpackage

// File: rtl/a23_copro_initiator.sv
// CP15 MCR/MRC master; macro A23_COPRO_NUM_CHECK_EN rejects num != 15 with rsp_err.
// Latency: rsp_valid 2 (MCR) / 3 (MRC) cycles after accept plus stall cycles spent in ISSUE.
// Backpressure: one transfer in flight; req_ready low until the response handshake completes.
module a23_copro_initiator
  import a23_copro_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_fetch_stall,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [2:0]        i_req_opcode1,
  input  logic [2:0]        i_req_opcode2,
  input  logic [3:0]        i_req_crn,
  input  logic [3:0]        i_req_crm,
  input  logic [3:0]        i_req_num,
  input  logic [DATA_W-1:0] i_req_wdata,
  input  logic [TAG_W-1:0]  i_req_tag,
  output logic [2:0]        o_copro_opcode1,
  output logic [2:0]        o_copro_opcode2,
  output logic [3:0]        o_copro_crn,
  output logic [3:0]        o_copro_crm,
  output logic [3:0]        o_copro_num,
  output logic [1:0]        o_copro_operation,
  output logic [DATA_W-1:0] o_copro_write_data,
  input  logic [DATA_W-1:0] i_copro_read_data,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic [TAG_W-1:0]  o_rsp_tag,
  output logic              o_rsp_write,
  output logic              o_rsp_err,
  output logic              o_busy
);

  copro_state_t state_q, state_d;
  logic         accept;
  logic         num_bad;

`ifdef A23_COPRO_NUM_CHECK_EN
  assign num_bad = (i_req_num != COPRO_NUM_CP15);
`else
  assign num_bad = 1'b0;
`endif

  assign accept = (state_q == IDLE) && i_req_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    o_req_ready       = 1'b0;
    o_rsp_valid       = 1'b0;
    o_copro_operation = COPRO_OP_IDLE;
    o_busy            = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) state_d = num_bad ? RESP : ISSUE;
      end
      ISSUE: begin
        o_copro_operation = o_rsp_write ? COPRO_OP_WRITE : COPRO_OP_READ;
        // An unstalled edge here is the one the coprocessor samples on.
        if (!i_fetch_stall) state_d = o_rsp_write ? RESP : CAPTURE;
      end
      CAPTURE: state_d = RESP;
      RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Field registers hold after the transfer so crn keeps steering the read mux.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_copro_opcode1    <= '0;
      o_copro_opcode2    <= '0;
      o_copro_crn        <= '0;
      o_copro_crm        <= '0;
      o_copro_num        <= '0;
      o_copro_write_data <= '0;
      o_rsp_rdata        <= '0;
      o_rsp_tag          <= '0;
      o_rsp_write        <= 1'b0;
    end else if (accept) begin
      o_copro_opcode1    <= i_req_opcode1;
      o_copro_opcode2    <= i_req_opcode2;
      o_copro_crn        <= i_req_crn;
      o_copro_crm        <= i_req_crm;
      o_copro_num        <= i_req_num;
      o_copro_write_data <= i_req_wdata;
      o_rsp_rdata        <= '0;
      o_rsp_tag          <= i_req_tag;
      o_rsp_write        <= i_req_write;
    end else if (state_q == CAPTURE) begin
      o_rsp_rdata <= i_copro_read_data;
    end
  end

`ifdef A23_COPRO_NUM_CHECK_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rsp_err <= 1'b0;
    end else if (accept) begin
      o_rsp_err <= num_bad;
    end
  end
`else
  assign o_rsp_err = 1'b0;
`endif

endmodule
